// File: rtl/crc_tx_sequencer_if.sv
// Byte-stream handshake between the TX packet unit (byte source) and the
// CRC transmit sequencer.
//   byte_in    : payload byte
//   byte_valid : byte_in is valid
//   byte_last  : byte_in is the final payload byte
//   byte_ready : sequencer accepts the byte this cycle
// master = byte source, slave = sequencer.
interface crc_tx_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/crc_tx_sequencer.sv
// Transmit-side controller sequencing the CRC calculator for one packet.
// Payload bytes arrive over byte_if and are serialised LSB-first, one bit per
// bit_tick, to the bit stuffer while each bit is mirrored into the CRC unit.
// After the last byte the CRC finish is commanded, the result is latched on
// crc_send and its 16 bits are sent MSB-first.
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   start, abort      : begin packet (IDLE only) / return to IDLE (non-IDLE)
//   bit_tick          : one strobe per bit period
//   byte_if           : byte_in / byte_valid / byte_last / byte_ready
//   crc_reset         : clear pulse to the CRC unit
//   crc_bit_in        : data bit to the CRC unit
//   crc_new_bit       : strobe to shift crc_bit_in into the CRC
//   crc_calc          : finish-CRC command (level)
//   crc_send          : CRC result ready
//   crc_bytes         : CRC result
//   tx_bit, tx_strobe : serial bit and its one-cycle valid
//   busy, done, error : not idle / packet-complete pulse / sticky error
//   byte_cnt          : bytes accepted in the current packet
module crc_tx_sequencer #(
  parameter int unsigned MAX_BYTES    = 64,
  parameter int unsigned CALC_TIMEOUT = 64,
  parameter bit          INVERT_CRC   = 1'b1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bit_tick,
  crc_tx_sequencer_if.slave        byte_if,
  output logic                     crc_reset,
  output logic                     crc_bit_in,
  output logic                     crc_new_bit,
  output logic                     crc_calc,
  input  logic                     crc_send,
  input  logic [15:0]              crc_bytes,
  output logic                     tx_bit,
  output logic                     tx_strobe,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [6:0]               byte_cnt
);

  localparam int unsigned   TW         = $clog2(CALC_TIMEOUT + 1);
  localparam logic [6:0]    MAX_CNT    = 7'(MAX_BYTES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CALC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DATA,
    ST_CALC,
    ST_CRC_OUT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    shift_q;
  logic          last_q;
  logic [2:0]    bit_cnt_q;
  logic [15:0]   hold_q;
  logic [3:0]    crc_cnt_q;
  logic [TW-1:0] timer_q;
  logic          abort_hit;

  assign abort_hit = abort && (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every state action, so strobes, byte acceptance and the
  // CRC latch are all suppressed in the abort cycle.
  always_comb begin
    state_d            = state_q;
    crc_reset          = 1'b0;
    crc_new_bit        = 1'b0;
    crc_calc           = 1'b0;
    tx_bit             = 1'b0;
    tx_strobe          = 1'b0;
    done               = 1'b0;
    byte_if.byte_ready = 1'b0;
    crc_bit_in         = (state_q == ST_DATA) ? shift_q[0] : 1'b0;

    if (abort_hit) begin
      state_d   = ST_IDLE;
      crc_reset = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          crc_reset = 1'b1;
          state_d   = ST_LOAD;
        end
        ST_LOAD: begin
          byte_if.byte_ready = 1'b1;
          if (byte_if.byte_valid) state_d = ST_DATA;
          else if (bit_tick)      state_d = ST_ERR;
        end
        ST_DATA: begin
          if (bit_tick) begin
            tx_bit      = shift_q[0];
            tx_strobe   = 1'b1;
            crc_new_bit = 1'b1;
            if (bit_cnt_q == 3'd7) begin
              if (last_q)                  state_d = ST_CALC;
              else if (byte_cnt == MAX_CNT) state_d = ST_ERR;
              else                          state_d = ST_LOAD;
            end
          end
        end
        ST_CALC: begin
          crc_calc = 1'b1;
          if (crc_send)                  state_d = ST_CRC_OUT;
          else if (timer_q == TIMER_LAST) state_d = ST_ERR;
        end
        ST_CRC_OUT: begin
          if (bit_tick) begin
            tx_bit    = hold_q[15];
            tx_strobe = 1'b1;
            if (crc_cnt_q == 4'd15) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        ST_ERR: begin
          crc_reset = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q   <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      crc_cnt_q <= '0;
      timer_q   <= '0;
      byte_cnt  <= '0;
      error     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        error    <= 1'b0;
        byte_cnt <= '0;
      end
      if (state_d == ST_ERR) begin
        error <= 1'b1;
      end

      if (byte_if.byte_ready && byte_if.byte_valid) begin
        shift_q   <= byte_if.byte_in;
        last_q    <= byte_if.byte_last;
        bit_cnt_q <= '0;
        byte_cnt  <= byte_cnt + 7'd1;
      end else if (crc_new_bit) begin
        shift_q   <= {1'b0, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (state_q == ST_CALC) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        timer_q <= '0;
      end

      if (state_q == ST_CALC && state_d == ST_CRC_OUT) begin
        hold_q    <= INVERT_CRC ? ~crc_bytes : crc_bytes;
        crc_cnt_q <= '0;
      end else if (state_q == ST_CRC_OUT && tx_strobe) begin
        hold_q    <= {hold_q[14:0], 1'b0};
        crc_cnt_q <= crc_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: doc/crc_tx_sequencer.md
Name: crc_tx_sequencer

Overview:
- Transmit-side controller that sequences the CRC calculator for one packet.
- Takes payload bytes over a valid/ready handshake and serialises them LSB-first, one bit per bit_tick, to the bit stuffer.
- Mirrors each data bit into the CRC unit. After the last byte it commands the CRC finish, waits for the CRC-ready indication, then serialises the 16 CRC bits.
- Sits between the TX packet unit (byte source) and the CRC calculator / bit stuffer.

Parameters:
- MAX_BYTES, 64, maximum payload bytes per packet; exceeding it without byte_last is an error.
- CALC_TIMEOUT, 64, cycles to wait for crc_send after crc_calc rises.
- INVERT_CRC, 1, when 1 the CRC bits are transmitted complemented.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a packet
- abort  in  1  synchronous abort, any state
- bit_tick  in  1  one-cycle strobe per bit period; guaranteed ≥4 clk apart
- byte_in  in  8  payload byte
- byte_valid  in  1  byte_in valid
- byte_last  in  1  qualifies byte_in as final payload byte
- byte_ready  out  1  sequencer accepts byte this cycle
- crc_reset  out  1  synchronous clear to CRC unit
- crc_bit_in  out  1  data bit to CRC unit
- crc_new_bit  out  1  one-cycle strobe: shift crc_bit_in into CRC
- crc_calc  out  1  finish-CRC command, level
- crc_send  in  1  CRC unit result ready
- crc_bytes  in  16  CRC result
- tx_bit  out  1  serial bit to bit stuffer
- tx_strobe  out  1  tx_bit valid, one cycle
- busy  out  1  not IDLE
- done  out  1  one-cycle packet-complete pulse
- error  out  1  sticky error flag; cleared on next accepted start
- byte_cnt  out  7  bytes accepted in current packet

Behaviour:
- Reset: state IDLE; all outputs 0; byte_cnt 0; internal shift, CRC hold and counters 0.
- States: IDLE, CLEAR, LOAD, DATA, CALC, CRC_OUT, DONE, ERR.
- IDLE:
  - start=1 clears error and byte_cnt, then goes to CLEAR.
  - Other inputs are ignored. start is also ignored in every non-IDLE state.
- CLEAR: crc_reset=1 for exactly one cycle, then LOAD.
- LOAD:
  - byte_ready=1.
  - byte_valid=1 latches byte_in and byte_last, sets bit_cnt=0, increments byte_cnt, then goes to DATA.
  - If byte_valid=1 and bit_tick=1 in the same cycle, the byte is captured and no bit is sent on that tick.
  - bit_tick with byte_valid=0 is an underrun and goes to ERR.
- DATA:
  - crc_bit_in = shift[0] continuously.
  - On bit_tick: tx_bit=shift[0], tx_strobe=1, crc_new_bit=1 (same cycle); shift right; bit_cnt++.
  - After the 8th bit: if last, go to CALC; else if byte_cnt==MAX_BYTES, go to ERR; else go to LOAD.
- CALC:
  - crc_calc=1; a timer counts cycles.
  - crc_send=1 latches crc_bytes (complemented if INVERT_CRC), drops crc_calc next cycle, and goes to CRC_OUT.
  - If the timer reaches CALC_TIMEOUT, go to ERR.
- CRC_OUT:
  - On each bit_tick, send hold[15] first (MSB-first), shift left, count.
  - After 16 bits, go to DONE.
  - crc_calc=0 throughout.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 (sticky), crc_reset=1 for one cycle, then IDLE.
- Abort:
  - abort=1 in any non-IDLE state sends the block to IDLE next cycle with crc_reset=1 that cycle.
  - No tx_strobe, no done, error unchanged.
  - abort has priority over bit_tick, byte_valid and crc_send.
- Timing: tx_strobe and crc_new_bit are asserted only in the bit_tick cycle, so tx_strobe never exceeds one per bit_tick.
- Async reset mid-packet returns everything to reset values immediately.

Test Plan:
- 2-byte packet 8'hA5, 8'h3C(last), CRC model returns 16'hBEEF on crc_send, INVERT_CRC=1 -> tx_bit sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, then bits of 16'h4110 MSB-first; exactly one done pulse; byte_cnt=2; crc_new_bit count=16.
- Withhold byte_valid in LOAD while bit_tick fires -> ERR; error=1; crc_reset pulse; busy=0; error clears on next start.
- CRC model never asserts crc_send -> crc_calc high exactly 64 cycles, then error=1, no CRC bits emitted.
- MAX_BYTES=4, stream 4 bytes none last -> error after 32 data tx_strobes, no crc_calc.
- abort coincident with bit_tick in DATA mid-byte -> no tx_strobe that cycle; IDLE next cycle; crc_reset=1; done=0.
- start pulsed during DATA and byte_valid asserted in DATA -> ignored; byte_ready stays 0; packet completes unchanged.
